// File: rtl/wait_mem.sv
// Single-port synchronous memory with a bidirectional data bus and a
// programmable wait-state access engine (IDLE -> [BUSY] -> DONE).
module wait_mem #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned MEM_DEPTH   = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  data_e,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data_io,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CntW = 4;
  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    win, accept, illegal, enter_done, commit_wr, in_range;
  logic                    cmd_wr;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [IdxW-1:0]         mem_idx;

  // Command decode, FSM next state, and completion effects.
  // With zero wait states the accept edge is also the completion edge, so the
  // completing command is taken straight from the bus rather than the latches.
  always_comb begin
    win       = (state_q != StBusy);
    accept    = win && ((rd && !wr) || (wr && data_e && !rd));
    illegal   = win && rd && wr;
    cmd_wr    = accept ? wr : op_wr_q;
    cmd_addr  = accept ? addr : addr_q;
    cmd_wdata = accept ? data_io : wdata_q;
    in_range  = (32'(cmd_addr) < MEM_DEPTH);
    mem_idx   = cmd_addr[IdxW-1:0];

    state_d    = state_q;
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    enter_done = 1'b0;
    commit_wr  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          op_wr_d = wr;
          addr_d  = addr;
          if (wr) wdata_d = data_io;
          if (WAIT_STATES == 0) begin
            state_d    = StDone;
            enter_done = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = CntW'(WAIT_STATES - 1);
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d    = StDone;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_done) begin
      if (cmd_wr) begin
        commit_wr = in_range;
      end else begin
        rdata_d = in_range ? mem_q[mem_idx] : '0;
      end
    end

    // Pulses for one cycle after an illegal command, or flags an
    // out-of-range access for the duration of DONE.
    err_d = illegal || (enter_done && !in_range);
  end

  // Control and datapath registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array: deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit_wr) mem_q[mem_idx] <= cmd_wdata;
  end

  assign ready   = (state_q == StDone);
  assign busy    = (state_q == StBusy);
  assign err     = err_q;
  assign data_io = (state_q == StDone && !op_wr_q) ? rdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_wait_mem.sv
// Bench for wait_mem: three instances (0/3/5 wait states, one with 20 words),
// a vector table, directed multi-cycle sequences and a randomized phase
// checked against an array-based model of the memory.
module tb_wait_mem;

  localparam int NI = 3;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_a   [NI];
  logic          wr_a   [NI];
  logic          de_a   [NI];
  logic [AW-1:0] addr_a [NI];
  logic          drv_en [NI];
  logic [DW-1:0] drv_d  [NI];
  wire  [DW-1:0] bus_obs [NI];
  logic          ready_a [NI];
  logic          busy_a  [NI];
  logic          err_a   [NI];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [NI][32];
  bit            known     [NI][32];

  typedef struct {
    bit            r;
    bit            w;
    bit            de;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            exp_ready;
    bit            exp_err;
    logic [DW-1:0] exp_bus;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    tri1 [DW-1:0] bus;
    assign bus = drv_en[g] ? drv_d[g] : {DW{1'bz}};
    assign bus_obs[g] = bus;
    wait_mem #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MEM_DEPTH  ((g == 1) ? 20 : 32),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd     (rd_a[g]),
      .wr     (wr_a[g]),
      .data_e (de_a[g]),
      .addr   (addr_a[g]),
      .data_io(bus),
      .ready  (ready_a[g]),
      .busy   (busy_a[g]),
      .err    (err_a[g])
    );
  end

  function automatic int ws_of(int i);
    if (i == 0) return 0;
    if (i == 1) return 3;
    return 5;
  endfunction

  function automatic int depth_of(int i);
    return (i == 1) ? 20 : 32;
  endfunction

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear(int i);
    rd_a[i]   = 1'b0;
    wr_a[i]   = 1'b0;
    de_a[i]   = 1'b0;
    drv_en[i] = 1'b0;
  endtask

  // Bus released reads as all ones through the pull-up.
  task automatic idle_chk(int i, string nm);
    chk1({nm, "_ready"}, ready_a[i], 1'b0);
    chk1({nm, "_busy"}, busy_a[i], 1'b0);
    chk1({nm, "_err"}, err_a[i], 1'b0);
    chk8({nm, "_bus"}, bus_obs[i], 8'hFF);
  endtask

  // One legal access: WS busy cycles, one ready cycle, then idle.
  task automatic do_access(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d, string nm);
    bit oor;
    oor = (int'(a) >= depth_of(i));
    @(posedge clk); #1;
    addr_a[i] = a;
    if (w) begin
      wr_a[i] = 1'b1; de_a[i] = 1'b1; drv_en[i] = 1'b1; drv_d[i] = d;
    end else begin
      rd_a[i] = 1'b1;
    end
    @(posedge clk); #1;
    clear(i);
    addr_a[i] = ~a;
    for (int c = 0; c < ws_of(i); c++) begin
      @(negedge clk);
      chk1({nm, "_busy"}, busy_a[i], 1'b1);
      chk1({nm, "_notready"}, ready_a[i], 1'b0);
    end
    @(negedge clk);
    chk1({nm, "_ready"}, ready_a[i], 1'b1);
    chk1({nm, "_err"}, err_a[i], oor);
    if (!w) begin
      if (oor) chk8({nm, "_data"}, bus_obs[i], 8'h00);
      else if (known[i][a]) chk8({nm, "_data"}, bus_obs[i], model_mem[i][a]);
    end else begin
      chk8({nm, "_wbus"}, bus_obs[i], 8'hFF);
      if (!oor) begin
        model_mem[i][a] = d;
        known[i][a]     = 1'b1;
      end
    end
    @(negedge clk);
    idle_chk(i, {nm, "_after"});
  endtask

  task automatic do_illegal(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    @(posedge clk); #1;
    addr_a[i] = a; rd_a[i] = 1'b1; wr_a[i] = 1'b1; de_a[i] = 1'b1;
    drv_en[i] = 1'b1; drv_d[i] = d;
    @(posedge clk); #1;
    clear(i);
    @(negedge clk);
    chk1("illegal_err", err_a[i], 1'b1);
    chk1("illegal_ready", ready_a[i], 1'b0);
    chk1("illegal_busy", busy_a[i], 1'b0);
    @(negedge clk);
    chk1("illegal_err_drop", err_a[i], 1'b0);
  endtask

  task automatic do_nowr(int i, logic [AW-1:0] a);
    @(posedge clk); #1;
    addr_a[i] = a; wr_a[i] = 1'b1;
    @(posedge clk); #1;
    clear(i);
    @(negedge clk);
    idle_chk(i, "nowr");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int            sel;
  int            kind;
  logic [AW-1:0] ra;
  logic [DW-1:0] rdat;

  initial begin
    tbl[0]  = '{r:0, w:1, de:1, a:3,  d:8'hA5, exp_ready:1, exp_err:0, exp_bus:8'hFF};
    tbl[1]  = '{r:0, w:1, de:1, a:0,  d:8'h11, exp_ready:1, exp_err:0, exp_bus:8'hFF};
    tbl[2]  = '{r:0, w:1, de:1, a:1,  d:8'h22, exp_ready:1, exp_err:0, exp_bus:8'hFF};
    tbl[3]  = '{r:0, w:1, de:1, a:2,  d:8'h33, exp_ready:1, exp_err:0, exp_bus:8'hFF};
    tbl[4]  = '{r:1, w:0, de:0, a:3,  d:8'h00, exp_ready:1, exp_err:0, exp_bus:8'hA5};
    tbl[5]  = '{r:1, w:1, de:1, a:3,  d:8'h00, exp_ready:0, exp_err:1, exp_bus:8'hFF};
    tbl[6]  = '{r:0, w:1, de:0, a:3,  d:8'h5A, exp_ready:0, exp_err:0, exp_bus:8'hFF};
    tbl[7]  = '{r:1, w:0, de:0, a:3,  d:8'h00, exp_ready:1, exp_err:0, exp_bus:8'hA5};
    tbl[8]  = '{r:0, w:0, de:0, a:3,  d:8'h00, exp_ready:0, exp_err:0, exp_bus:8'hFF};
    tbl[9]  = '{r:1, w:0, de:0, a:1,  d:8'h00, exp_ready:1, exp_err:0, exp_bus:8'h22};
    tbl[10] = '{r:0, w:1, de:1, a:31, d:8'h0F, exp_ready:1, exp_err:0, exp_bus:8'hFF};
    tbl[11] = '{r:1, w:0, de:0, a:31, d:8'h00, exp_ready:1, exp_err:0, exp_bus:8'h0F};

    for (int i = 0; i < NI; i++) begin
      clear(i);
      addr_a[i] = '0;
      drv_d[i]  = '0;
    end

    // Reset state on every instance.
    @(negedge clk);
    for (int i = 0; i < NI; i++) idle_chk(i, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table on the zero-wait instance.
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      rd_a[0]   = tbl[k].r;
      wr_a[0]   = tbl[k].w;
      de_a[0]   = tbl[k].de;
      addr_a[0] = tbl[k].a;
      drv_en[0] = tbl[k].w && tbl[k].de;
      drv_d[0]  = tbl[k].d;
      @(posedge clk); #1;
      clear(0);
      @(negedge clk);
      chk1($sformatf("vec%0d_ready", k), ready_a[0], tbl[k].exp_ready);
      chk1($sformatf("vec%0d_err", k), err_a[0], tbl[k].exp_err);
      chk8($sformatf("vec%0d_bus", k), bus_obs[0], tbl[k].exp_bus);
      if (tbl[k].w && tbl[k].de && !tbl[k].r) begin
        model_mem[0][tbl[k].a] = tbl[k].d;
        known[0][tbl[k].a]     = 1'b1;
      end
    end

    // Back-to-back reads of addresses 0,1,2 on consecutive edges.
    @(posedge clk); #1;
    rd_a[0] = 1'b1; addr_a[0] = 5'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k < 2) addr_a[0] = AW'(k + 1);
      else rd_a[0] = 1'b0;
      @(negedge clk);
      chk1($sformatf("b2b%0d_ready", k), ready_a[0], 1'b1);
      chk8($sformatf("b2b%0d_data", k), bus_obs[0], model_mem[0][k]);
    end
    @(negedge clk);
    idle_chk(0, "b2b_after");

    // Three wait states, 20 words: preload, then write/read addr 7.
    for (int a = 0; a < 20; a++) do_access(1, 1'b1, AW'(a), DW'(a * 13 + 5), "pre1");
    do_access(1, 1'b1, 5'd7, 8'h3C, "ws3_wr7");
    do_access(1, 1'b0, 5'd7, 8'h00, "ws3_rd7");

    // Read pulse during BUSY must be ignored.
    @(posedge clk); #1;
    rd_a[1] = 1'b1; addr_a[1] = 5'd7;
    @(posedge clk); #1;
    rd_a[1] = 1'b0;
    @(negedge clk);
    chk1("busyrd_b1", busy_a[1], 1'b1);
    @(posedge clk); #1;
    rd_a[1] = 1'b1; addr_a[1] = 5'd0;
    @(negedge clk);
    chk1("busyrd_b2", busy_a[1], 1'b1);
    @(posedge clk); #1;
    rd_a[1] = 1'b0;
    @(negedge clk);
    chk1("busyrd_b3", busy_a[1], 1'b1);
    @(negedge clk);
    chk1("busyrd_ready", ready_a[1], 1'b1);
    chk8("busyrd_data", bus_obs[1], 8'h3C);
    @(negedge clk);
    idle_chk(1, "busyrd_after");

    // Out-of-range read and write, then confirm all 20 words intact.
    do_access(1, 1'b0, 5'd25, 8'h00, "oor_rd");
    do_access(1, 1'b1, 5'd25, 8'hEE, "oor_wr");
    do_illegal(1, 5'd7, 8'h99);
    do_nowr(1, 5'd7);
    for (int a = 0; a < 20; a++) do_access(1, 1'b0, AW'(a), 8'h00, "post_oor");

    // Reset in the second BUSY cycle of a write on the five-wait instance.
    do_access(2, 1'b1, 5'd4, 8'h77, "ws5_pre");
    @(posedge clk); #1;
    addr_a[2] = 5'd4; wr_a[2] = 1'b1; de_a[2] = 1'b1; drv_en[2] = 1'b1; drv_d[2] = 8'h99;
    @(posedge clk); #1;
    clear(2);
    @(negedge clk);
    chk1("rst_mid_busy1", busy_a[2], 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_busy", busy_a[2], 1'b0);
    chk1("rst_mid_ready", ready_a[2], 1'b0);
    chk8("rst_mid_bus", bus_obs[2], 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    do_access(2, 1'b0, 5'd4, 8'h00, "rst_mid_rd4");

    // Randomized traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      sel  = $urandom_range(0, NI - 1);
      kind = $urandom_range(0, 9);
      ra   = AW'($urandom_range(0, 31));
      rdat = DW'($urandom_range(0, 255));
      if (kind <= 3) do_access(sel, 1'b0, ra, 8'h00, "rnd_rd");
      else if (kind <= 7) do_access(sel, 1'b1, ra, rdat, "rnd_wr");
      else if (kind == 8) do_illegal(sel, ra, rdat);
      else do_nowr(sel, ra);
    end

    // Final sweep of every known word on every instance.
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 32; a++)
        if (known[i][a]) do_access(i, 1'b0, AW'(a), 8'h00, "sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
